// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : UART transmitter; sends one 8-bit frame LSB-first with an
//            optional parity bit and 1 or 2 stop bits.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLKS_PER_BIT = 10,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       Rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int              c_TW    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_TW-1:0] c_TLAST = c_TW'(CLKS_PER_BIT - 1);
    localparam logic            c_ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t            r_state;
    logic [c_TW-1:0]   r_timer;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic              r_parity;

    logic w_wrap;
    logic w_stop_last;

    assign w_wrap      = (r_timer == c_TLAST);
    assign w_stop_last = (STOP_BITS == 2) ? r_bit_cnt[0] : 1'b1;

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            tx_out    <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            // Outputs follow the state one cycle later, giving the 1-cycle start latency
            tx_busy <= (r_state != S_IDLE);
            tx_done <= (r_state == S_IDLE) && tx_busy;
            case (r_state)
                S_START:  tx_out <= 1'b0;
                S_DATA:   tx_out <= r_shift[0];
                S_PARITY: tx_out <= r_parity;
                default:  tx_out <= 1'b1;
            endcase

            if (r_state != S_IDLE) begin
                r_timer <= w_wrap ? '0 : r_timer + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (tx_start) begin
                        r_state   <= S_START;
                        r_shift   <= tx_data;
                        r_parity  <= (^tx_data) ^ c_ODD;
                        r_timer   <= '0;
                        r_bit_cnt <= '0;
                    end
                end
                S_START: begin
                    if (w_wrap) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_wrap) begin
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_wrap) begin
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    // Counter re-enters STOP at zero after wrapping from 7 in DATA
                    if (w_wrap) begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (w_stop_last) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Scoreboard bench for uart_tx across several parameter sets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int c_N = 5;
    localparam int c_CPB  [c_N] = '{10, 10, 3, 10, 2};
    localparam int c_PEN  [c_N] = '{ 0,  1, 1,  0, 1};
    localparam int c_PODD [c_N] = '{ 0,  0, 1,  0, 0};
    localparam int c_STOP [c_N] = '{ 1,  1, 1,  2, 2};

    typedef struct packed {
        logic [7:0] d;
        int         e;
    } frame_t;

    logic       clk;
    logic       rst_a    [c_N];
    logic [7:0] tx_data  [c_N];
    logic       tx_start [c_N];
    logic       tx_out   [c_N];
    logic       tx_busy  [c_N];
    logic       tx_done  [c_N];

    int     cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    int     next_ok [c_N];
    int     last_e  [c_N];
    frame_t q [c_N][$];

    for (genvar gi = 0; gi < c_N; gi++) begin : g_dut
        uart_tx #(
            .CLKS_PER_BIT(c_CPB[gi]),
            .PARITY_EN   (c_PEN[gi]),
            .PARITY_ODD  (c_PODD[gi]),
            .STOP_BITS   (c_STOP[gi])
        ) u_dut (
            .clk     (clk),
            .Rst     (rst_a[gi]),
            .tx_data (tx_data[gi]),
            .tx_start(tx_start[gi]),
            .tx_out  (tx_out[gi]),
            .tx_busy (tx_busy[gi]),
            .tx_done (tx_done[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int frame_len(input int n);
        return (10 + c_PEN[n] + c_STOP[n] - 1) * c_CPB[n];
    endfunction

    // Line level of serial bit slot idx of a frame carrying d
    function automatic logic exp_bit(input int n, input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (idx == 9 && c_PEN[n] != 0) return (^d) ^ (c_PODD[n] != 0);
        return 1'b1;
    endfunction

    task automatic check(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s u%0d cyc=%0d: got %0h want %0h", nm, n, cyc, act, exp);
        end
    endtask

    // Called just after a rising edge; inputs are sampled at the next edge
    task automatic step(input int n, input bit s, input logic [7:0] d, output bit acc);
        frame_t f;
        tx_start[n] = s;
        tx_data[n]  = d;
        acc = 1'b0;
        if (s && !rst_a[n] && (cyc + 1 >= next_ok[n])) begin
            f.d = d;
            f.e = cyc + 1;
            q[n].push_back(f);
            last_e[n]  = cyc + 1;
            next_ok[n] = cyc + 1 + frame_len(n) + 1;
            acc = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wait(input int n);
        bit acc;
        while (cyc + 1 < next_ok[n]) step(n, 1'b0, 8'($urandom), acc);
    endtask

    task automatic send(input int n, input logic [7:0] d);
        bit acc;
        step(n, 1'b1, d, acc);
        check("start_accepted", n, 32'(acc), 32'd1);
    endtask

    task automatic driver(input int n);
        bit acc;
        int k;
        int target;
        repeat (3) @(posedge clk);
        #1;
        rst_a[n]   = 1'b0;
        next_ok[n] = cyc + 1;
        step(n, 1'b0, 8'h00, acc);

        send(n, 8'hA5); idle_wait(n);
        send(n, 8'h07); idle_wait(n);

        // Start held high across two frames
        acc = 1'b0;
        while (!acc) step(n, 1'b1, 8'h00, acc);
        acc = 1'b0;
        while (!acc) step(n, 1'b1, 8'hFF, acc);
        step(n, 1'b0, 8'hFF, acc);
        idle_wait(n);

        // Start pulse and data change while busy
        send(n, 8'h3C);
        k = (frame_len(n) / 2 < 40) ? frame_len(n) / 2 : 40;
        for (int i = 1; i < k; i++) step(n, 1'b0, 8'h3C, acc);
        step(n, 1'b1, 8'h81, acc);
        step(n, 1'b0, 8'h81, acc);
        idle_wait(n);
        repeat (4) step(n, 1'b0, 8'h81, acc);

        // Asynchronous reset inside data bit 3
        send(n, 8'h55);
        target = last_e[n] + 1 + 4 * c_CPB[n] + c_CPB[n] / 2;
        while (cyc < target) step(n, 1'b0, 8'h55, acc);
        #2;
        rst_a[n]    = 1'b1;
        tx_start[n] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_a[n]   = 1'b0;
        next_ok[n] = cyc + 1;
        repeat (2) step(n, 1'b0, 8'h00, acc);
        send(n, 8'h12); idle_wait(n);

        repeat (300) step(n, ($urandom_range(0, 5) == 0), 8'($urandom), acc);
        step(n, 1'b0, 8'h00, acc);
        idle_wait(n);
        repeat (3) step(n, 1'b0, 8'h00, acc);
    endtask

    task automatic monitor(input int n);
        bit         in_f;
        int         t;
        frame_t     cur;
        logic [2:0] act;
        logic [2:0] exp;
        in_f = 1'b0;
        t    = 0;
        cur  = '0;
        forever begin
            @(negedge clk);
            act = {tx_out[n], tx_busy[n], tx_done[n]};
            if (rst_a[n]) begin
                check("reset_outputs", n, 32'(act), 32'b100);
                in_f = 1'b0;
            end else begin
                if (!in_f) begin
                    if (tx_busy[n] && q[n].size() > 0) begin
                        cur = q[n].pop_front();
                        check("start_latency", n, cyc, cur.e + 1);
                        in_f = 1'b1;
                        t    = 0;
                    end else begin
                        check("idle_line", n, 32'(act), 32'b100);
                    end
                end
                if (in_f) begin
                    exp = (t == frame_len(n)) ? 3'b101 : {exp_bit(n, cur.d, t / c_CPB[n]), 2'b10};
                    check("frame_cycle", n, 32'(act), 32'(exp));
                    if (t == frame_len(n)) in_f = 1'b0;
                    t++;
                end
            end
        end
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: cycle budget expired at cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < c_N; i++) begin
            rst_a[i]    = 1'b1;
            tx_start[i] = 1'b0;
            tx_data[i]  = 8'h00;
            next_ok[i]  = 0;
            last_e[i]   = 0;
        end
        for (int i = 0; i < c_N; i++) begin
            automatic int k = i;
            fork
                monitor(k);
            join_none
        end
        fork
            driver(0);
            driver(1);
            driver(2);
            driver(3);
            driver(4);
        join
        repeat (5) @(negedge clk);
        for (int i = 0; i < c_N; i++) begin
            check("frames_outstanding", i, 32'(q[i].size()), 32'd0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
# uart_tx

Transmit half of the UART debugger link. It accepts a byte over a single-cycle start handshake and serializes it LSB-first as one frame: start bit, 8 data bits, optional parity, 1 or 2 stop bits. It drives the serial line back to the host and is the counterpart of the receive path (receive control unit, start-bit detector, bit counter). It contains its own baud timer, bit counter, shift register and control FSM.

## Interface
- CLKS_PER_BIT, 10, clock cycles per serial bit; legal values are 2 or more.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, selects odd parity when 1 and even parity when 0; ignored if PARITY_EN=0.
- STOP_BITS, 1, number of stop bits; legal values are 1 or 2.

- clk  input  1  system clock; all state updates on the rising edge.
- Rst  input  1  reset, asynchronous, active-high.
- tx_data  input  8  byte to send; sampled only on the cycle a start is accepted.
- tx_start  input  1  send request; honoured only while idle.
- tx_out  output  1  serial line; idles high.
- tx_busy  output  1  high from the cycle after acceptance until the last stop bit completes.
- tx_done  output  1  one-cycle pulse marking frame completion.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: leaves on tx_start=1 and goes to START.
  - START: after CLKS_PER_BIT cycles, goes to DATA.
  - DATA: after 8 bit periods, goes to PARITY if PARITY_EN=1, otherwise to STOP.
  - PARITY: after 1 bit period, goes to STOP.
  - STOP: after STOP_BITS bit periods, goes to IDLE.
- Acceptance:
  - In IDLE with tx_start=1, tx_data is latched into the shift register.
  - Parity is computed from the latched byte: XOR of its bits, inverted if PARITY_ODD.
  - The baud timer is cleared and the bit counter is cleared.
- Baud timer: counts 0..CLKS_PER_BIT-1 and wraps. The wrap marks the end of a bit period, which advances the bit counter and shifts the data.
- Bit counter: 3 bits. DATA exits when the counter is at 7 and the timer wraps. STOP uses the counter LSB when STOP_BITS=2.
- Data order: bit 0 first. tx_out = shift_reg[0], and the register shifts right once per bit period in DATA.
- tx_out per state:
  - IDLE: 1.
  - START: 0.
  - DATA: the current data bit.
  - PARITY: the parity bit.
  - STOP: 1.
- tx_out, tx_busy and tx_done are registered outputs; no combinational path from any input.
- tx_start while busy is ignored and is not queued.
- Changes to tx_data after acceptance have no effect on the frame in flight.
- Reset values: tx_out=1, tx_busy=0, tx_done=0, state=IDLE, counters=0, shift register=0.
- Reset mid-frame: the frame is aborted. tx_out returns to 1 asynchronously, and no tx_done is issued for the aborted frame.

## Timing
- Frame length: F = (10 + PARITY_EN + STOP_BITS - 1) × CLKS_PER_BIT cycles.
- Acceptance and frame start: tx_start is sampled high at edge k. From edge k+1, tx_out=0 and tx_busy=1.
- Bit boundaries: data bit i is driven during cycles k+1+(i+1)·CLKS_PER_BIT through k+(i+2)·CLKS_PER_BIT.
- Frame completion: at edge k+1+F, tx_busy=0 and tx_done=1 for exactly one cycle, with tx_out=1.
- Back-to-back frames:
  - tx_start is accepted in the same cycle tx_done is high, because the FSM is in IDLE.
  - The next start bit begins at edge k+2+F.
  - The minimum inter-frame idle on tx_out is therefore 1 cycle.
- Start latency: 1 cycle from tx_start sampled to start bit on the line.

## Test plan
- Basic frame (CLKS_PER_BIT=10): tx_data=0xA5, 1-cycle tx_start.
  - tx_out, sampled at the middle of each bit, reads 0,1,0,1,0,0,1,0,1,1.
  - tx_busy stays high for exactly 100 cycles, then tx_done pulses once.
- Parity: PARITY_EN=1, PARITY_ODD=0, tx_data=0x07.
  - The bit after the data bits is 1, and the frame is 110 cycles.
  - With PARITY_ODD=1, the same byte gives a parity bit of 0.
- Back-to-back frames with STOP_BITS=2: tx_start is held high continuously with 0x00 then 0xFF.
  - Two 110-cycle frames separated by exactly 1 high idle cycle.
  - tx_done pulses twice.
- Ignored start: tx_start is pulsed at cycle 40 of a 0x3C frame while tx_data changes to 0x81.
  - The line still carries 0x3C.
  - No second frame follows.
  - Exactly one tx_done.
- Reset mid-frame: Rst is asserted asynchronously during data bit 3 of 0x55.
  - tx_out=1, tx_busy=0 and tx_done=0 immediately.
  - After release, a new 0x12 frame is transmitted correctly with nominal timing.
